// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory handshake and retire counter
module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    input  logic                   memReady,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   iorD,
    output logic                   irWrite,
    output logic                   pcWrite,
    output logic [1:0]             pcSource,
    output logic                   regWrite,
    output logic                   regDst,
    output logic                   memToReg,
    output logic                   aluSrcA,
    output logic [1:0]             aluSrcB,
    output logic [4:0]             aluControl,
    output logic                   aluCarryIn,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] instrCount,
    output logic [3:0]             state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01010;
    localparam logic [4:0] ALU_SLT = 5'b01011;
    localparam logic [4:0] ALU_NOR = 5'b11000;

    localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state_q;
    state_t next_state;
    logic   retire;

    assign state      = state_q;
    assign aluCarryIn = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FETCH;
            instrCount <= '0;
            halted     <= 1'b0;
        end else begin
            state_q <= next_state;
            halted  <= (next_state == TRAP);
            if (retire) begin
                instrCount <= instrCount + ONE;
            end
        end
    end

    always_comb begin
        next_state = state_q;
        retire     = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        iorD       = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSource   = 2'd0;
        regWrite   = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'd0;
        aluControl = ALU_ADD;

        case (state_q)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'd1;
                if (memReady) begin
                    irWrite    = 1'b1;
                    pcWrite    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                aluSrcB = 2'd3;
                case (opcode)
                    6'b000000:            next_state = R_EXEC;
                    6'b100011, 6'b101011: next_state = MEM_ADDR;
                    6'b000100:            next_state = BRANCH;
                    6'b000010:            next_state = JUMP;
                    6'b001000:            next_state = ADDI_EXEC;
                    default:              next_state = TRAP;
                endcase
            end
            R_EXEC: begin
                aluSrcA    = 1'b1;
                next_state = R_WB;
                case (funct)
                    6'b100000: aluControl = ALU_ADD;
                    6'b100010: aluControl = ALU_SUB;
                    6'b100100: aluControl = ALU_AND;
                    6'b100101: aluControl = ALU_OR;
                    6'b100111: aluControl = ALU_NOR;
                    6'b101010: aluControl = ALU_SLT;
                    default:   next_state = TRAP;
                endcase
            end
            R_WB: begin
                regWrite   = 1'b1;
                regDst     = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEM_ADDR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'd2;
                // opcode still holds lw or sw here; DECODE filtered everything else
                next_state = (opcode == 6'b100011) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) begin
                    next_state = MEM_WB;
                end
            end
            MEM_WB: begin
                regWrite   = 1'b1;
                memToReg   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (memReady) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            BRANCH: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_SUB;
                pcSource   = 2'd1;
                pcWrite    = zero;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pcWrite    = 1'b1;
                pcSource   = 2'd2;
                retire     = 1'b1;
                next_state = FETCH;
            end
            ADDI_EXEC: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'd2;
                next_state = ADDI_WB;
            end
            ADDI_WB: begin
                regWrite   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            default: next_state = TRAP;
        endcase

        // Reset must drop any in-flight memory request in the same cycle
        if (reset) begin
            memRead    = 1'b0;
            memWrite   = 1'b0;
            iorD       = 1'b0;
            irWrite    = 1'b0;
            pcWrite    = 1'b0;
            pcSource   = 2'd0;
            regWrite   = 1'b0;
            regDst     = 1'b0;
            memToReg   = 1'b0;
            aluSrcA    = 1'b0;
            aluSrcB    = 2'd0;
            aluControl = 5'd0;
            retire     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    localparam int CW = 4;

    localparam logic [4:0] A_AND = 5'b00000;
    localparam logic [4:0] A_OR  = 5'b00001;
    localparam logic [4:0] A_ADD = 5'b00010;
    localparam logic [4:0] A_SUB = 5'b01010;
    localparam logic [4:0] A_SLT = 5'b01011;
    localparam logic [4:0] A_NOR = 5'b11000;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    opcode = 6'd0;
    logic [5:0]    funct = 6'd0;
    logic          zero = 1'b0;
    logic          memReady = 1'b0;
    logic          memRead, memWrite, iorD, irWrite, pcWrite;
    logic [1:0]    pcSource;
    logic          regWrite, regDst, memToReg, aluSrcA;
    logic [1:0]    aluSrcB;
    logic [4:0]    aluControl;
    logic          aluCarryIn, halted;
    logic [CW-1:0] instrCount;
    logic [3:0]    state;

    always #5 clock = ~clock;

    multicycle_control #(.COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .memReady(memReady), .memRead(memRead), .memWrite(memWrite),
        .iorD(iorD), .irWrite(irWrite), .pcWrite(pcWrite), .pcSource(pcSource),
        .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl),
        .aluCarryIn(aluCarryIn), .halted(halted), .instrCount(instrCount),
        .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mr, mw, iord, irw, pcw;
        logic [1:0] pcs;
        logic       rw, rd, m2r, asa;
        logic [1:0] asb;
        logic [4:0] alu;
        logic       cin, halt;
        logic [3:0] cnt;
    } obs_t;

    typedef struct {
        logic       chk, rst, mrdy, z;
        logic [5:0] op, fn;
        obs_t       e;
    } step_t;

    step_t      sq[$];
    int         total = 0;
    int         bad = 0;
    logic [3:0] cnt_m = 4'd0;

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.mr = memRead; o.mw = memWrite; o.iord = iorD;
        o.irw = irWrite; o.pcw = pcWrite; o.pcs = pcSource; o.rw = regWrite;
        o.rd = regDst; o.m2r = memToReg; o.asa = aluSrcA; o.asb = aluSrcB;
        o.alu = aluControl; o.cin = aluCarryIn; o.halt = halted; o.cnt = instrCount;
        return o;
    endfunction

    // Fixed per-state control values written out from the state descriptions
    function automatic obs_t base(input logic [3:0] s);
        obs_t e = '0;
        e.st = s; e.cnt = cnt_m; e.alu = A_ADD; e.halt = (s == 4'd12);
        case (s)
            4'd0:  begin e.mr = 1'b1; e.asb = 2'd1; end
            4'd1:  e.asb = 2'd3;
            4'd2:  begin e.asa = 1'b1; e.asb = 2'd2; end
            4'd3:  begin e.mr = 1'b1; e.iord = 1'b1; end
            4'd4:  begin e.rw = 1'b1; e.m2r = 1'b1; end
            4'd5:  begin e.mw = 1'b1; e.iord = 1'b1; end
            4'd6:  e.asa = 1'b1;
            4'd7:  begin e.rw = 1'b1; e.rd = 1'b1; end
            4'd8:  begin e.asa = 1'b1; e.alu = A_SUB; e.pcs = 2'd1; end
            4'd9:  begin e.pcw = 1'b1; e.pcs = 2'd2; end
            4'd10: begin e.asa = 1'b1; e.asb = 2'd2; end
            4'd11: e.rw = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic enq(input logic chk, input logic rst, input logic mrdy, input logic z,
                       input logic [5:0] op, input logic [5:0] fn, input obs_t e);
        step_t s;
        s.chk = chk; s.rst = rst; s.mrdy = mrdy; s.z = z; s.op = op; s.fn = fn; s.e = e;
        sq.push_back(s);
    endtask

    task automatic push_fetch(input int waits, input logic [5:0] op, input logic [5:0] fn);
        obs_t e;
        for (int i = 0; i < waits; i++) enq(1, 0, 0, 0, op, fn, base(4'd0));
        e = base(4'd0); e.irw = 1'b1; e.pcw = 1'b1;
        enq(1, 0, 1, 0, op, fn, e);
        enq(1, 0, 1, 0, op, fn, base(4'd1));
    endtask

    task automatic push_reset();
        enq(0, 1, 0, 0, 6'd0, 6'd0, '0);
        cnt_m = 4'd0;
        enq(1, 1, 0, 0, 6'd0, 6'd0, '0);
    endtask

    task automatic test_reset();
        step_t s; obs_t o;
        push_reset();
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge clock); #1;
            reset = s.rst; memReady = s.mrdy; zero = s.z; opcode = s.op; funct = s.fn;
            @(negedge clock);
            if (s.chk) begin
                total++; o = sample();
                if (o !== s.e) begin bad++; $display("FAIL reset got=%h exp=%h", o, s.e); end
            end
        end
    endtask

    task automatic test_rtype();
        step_t s; obs_t o, e;
        logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
        logic [4:0] alus [6] = '{A_ADD, A_SUB, A_AND, A_OR, A_NOR, A_SLT};
        for (int i = 0; i < 6; i++) begin
            push_fetch(0, OP_R, fns[i]);
            e = base(4'd6); e.alu = alus[i];
            enq(1, 0, 1, 0, OP_R, fns[i], e);
            enq(1, 0, 1, 0, OP_R, fns[i], base(4'd7));
            cnt_m = cnt_m + 4'd1;
        end
        enq(1, 0, 0, 0, OP_R, 6'd0, base(4'd0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge clock); #1;
            reset = s.rst; memReady = s.mrdy; zero = s.z; opcode = s.op; funct = s.fn;
            @(negedge clock);
            if (s.chk) begin
                total++; o = sample();
                if (o !== s.e) begin bad++; $display("FAIL rtype got=%h exp=%h", o, s.e); end
            end
        end
    endtask

    task automatic test_mem();
        step_t s; obs_t o;
        push_fetch(3, OP_LW, 6'd0);
        enq(1, 0, 1, 0, OP_LW, 6'd0, base(4'd2));
        enq(1, 0, 0, 0, OP_LW, 6'd0, base(4'd3));
        enq(1, 0, 0, 0, OP_LW, 6'd0, base(4'd3));
        enq(1, 0, 1, 0, OP_LW, 6'd0, base(4'd3));
        enq(1, 0, 1, 0, OP_LW, 6'd0, base(4'd4));
        cnt_m = cnt_m + 4'd1;
        push_fetch(0, OP_SW, 6'd0);
        enq(1, 0, 1, 0, OP_SW, 6'd0, base(4'd2));
        enq(1, 0, 1, 0, OP_SW, 6'd0, base(4'd5));
        cnt_m = cnt_m + 4'd1;
        push_fetch(0, OP_ADDI, 6'd0);
        enq(1, 0, 1, 0, OP_ADDI, 6'd0, base(4'd10));
        enq(1, 0, 1, 0, OP_ADDI, 6'd0, base(4'd11));
        cnt_m = cnt_m + 4'd1;
        enq(1, 0, 0, 0, OP_R, 6'd0, base(4'd0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge clock); #1;
            reset = s.rst; memReady = s.mrdy; zero = s.z; opcode = s.op; funct = s.fn;
            @(negedge clock);
            if (s.chk) begin
                total++; o = sample();
                if (o !== s.e) begin bad++; $display("FAIL mem st=%0d got=%h exp=%h", s.e.st, o, s.e); end
            end
        end
    endtask

    task automatic test_branch();
        step_t s; obs_t o, e;
        push_fetch(0, OP_BEQ, 6'd0);
        e = base(4'd8); e.pcw = 1'b1;
        enq(1, 0, 1, 1, OP_BEQ, 6'd0, e);
        cnt_m = cnt_m + 4'd1;
        push_fetch(0, OP_BEQ, 6'd0);
        enq(1, 0, 1, 0, OP_BEQ, 6'd0, base(4'd8));
        cnt_m = cnt_m + 4'd1;
        enq(1, 0, 0, 1, OP_R, 6'd0, base(4'd0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge clock); #1;
            reset = s.rst; memReady = s.mrdy; zero = s.z; opcode = s.op; funct = s.fn;
            @(negedge clock);
            if (s.chk) begin
                total++; o = sample();
                if (o !== s.e) begin bad++; $display("FAIL branch got=%h exp=%h", o, s.e); end
            end
        end
    endtask

    task automatic test_trap();
        step_t s; obs_t o;
        push_fetch(0, 6'b111111, 6'd0);
        for (int i = 0; i < 20; i++) enq(1, 0, i[0], i[1], 6'b111111, 6'd0, base(4'd12));
        push_reset();
        push_fetch(0, OP_R, 6'b000001);
        enq(1, 0, 1, 0, OP_R, 6'b000001, base(4'd6));
        for (int i = 0; i < 20; i++) enq(1, 0, i[0], 1'b0, OP_R, 6'b100000, base(4'd12));
        push_reset();
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge clock); #1;
            reset = s.rst; memReady = s.mrdy; zero = s.z; opcode = s.op; funct = s.fn;
            @(negedge clock);
            if (s.chk) begin
                total++; o = sample();
                if (o !== s.e) begin bad++; $display("FAIL trap st=%0d got=%h exp=%h", s.e.st, o, s.e); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        step_t s; obs_t o, e;
        push_fetch(0, OP_J, 6'd0);
        enq(1, 0, 1, 0, OP_J, 6'd0, base(4'd9));
        cnt_m = cnt_m + 4'd1;
        push_fetch(0, OP_SW, 6'd0);
        enq(1, 0, 1, 0, OP_SW, 6'd0, base(4'd2));
        enq(1, 0, 0, 0, OP_SW, 6'd0, base(4'd5));
        e = '0; e.st = 4'd5; e.cnt = cnt_m;
        enq(1, 1, 1, 0, OP_SW, 6'd0, e);
        cnt_m = 4'd0;
        enq(1, 0, 0, 0, OP_SW, 6'd0, base(4'd0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge clock); #1;
            reset = s.rst; memReady = s.mrdy; zero = s.z; opcode = s.op; funct = s.fn;
            @(negedge clock);
            if (s.chk) begin
                total++; o = sample();
                if (o !== s.e) begin bad++; $display("FAIL rst_write got=%h exp=%h", o, s.e); end
            end
        end
    endtask

    task automatic test_back_to_back_wrap();
        step_t s; obs_t o;
        for (int i = 0; i < 16; i++) begin
            push_fetch(0, OP_J, 6'd0);
            enq(1, 0, 1, 0, OP_J, 6'd0, base(4'd9));
            cnt_m = cnt_m + 4'd1;
        end
        enq(1, 0, 0, 0, OP_J, 6'd0, base(4'd0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge clock); #1;
            reset = s.rst; memReady = s.mrdy; zero = s.z; opcode = s.op; funct = s.fn;
            @(negedge clock);
            if (s.chk) begin
                total++; o = sample();
                if (o !== s.e) begin bad++; $display("FAIL wrap cnt=%0d got=%h exp=%h", s.e.cnt, o, s.e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_branch();
        test_trap();
        test_reset_mid_write();
        test_back_to_back_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
